// File: rtl/quad_step_decoder.sv
// Quadrature front-end: two-flop synchronisers, per-phase persistence filters and a Gray-code
// step decoder that emits the enable/up_en/down_en strobes for an up/down counter.
module quad_step_decoder #(
    parameter int FILT_LEN = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             dec_en,
    output logic             enable,
    output logic             up_en,
    output logic             down_en,
    output logic             dir,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_LEN - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t           r_state, w_state_next;
    logic             r_a_meta, r_a_sync, r_b_meta, r_b_sync;
    logic [1:0]       r_filt, w_filt_next;
    logic [1:0]       r_prev, w_prev_next;
    logic [CNT_W-1:0] r_cnt_a, w_cnt_a_next, r_cnt_b, w_cnt_b_next;
    logic [1:0]       r_init_cnt, w_init_cnt_next;
    logic             r_enable, w_enable_next, r_up, w_up_next, r_down, w_down_next;
    logic             r_err, w_err_next, r_dir, w_dir_next;
    logic [ERR_W-1:0] r_err_count, w_err_count_next;
    logic [1:0]       w_sync;
    logic [CNT_W:0]   w_step_a, w_step_b;

    assign w_sync = {r_a_sync, r_b_sync};

    // Returns {new filtered level, new persistence count} for one phase.
    function automatic logic [CNT_W:0] filt_step(input logic sync, input logic filt,
                                                 input logic [CNT_W-1:0] cnt);
        logic [CNT_W:0] res;
        if (sync == filt) begin
            res = {filt, {CNT_W{1'b0}}};
        end else if (cnt == FILT_LAST) begin
            res = {sync, {CNT_W{1'b0}}};
        end else begin
            res = {filt, cnt + {{(CNT_W-1){1'b0}}, 1'b1}};
        end
        return res;
    endfunction

    assign w_step_a = filt_step(w_sync[1], r_filt[1], r_cnt_a);
    assign w_step_b = filt_step(w_sync[0], r_filt[0], r_cnt_b);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, filter update and step/error decode.
    always_comb begin
        w_state_next     = r_state;
        w_filt_next      = r_filt;
        w_prev_next      = r_prev;
        w_cnt_a_next     = r_cnt_a;
        w_cnt_b_next     = r_cnt_b;
        w_init_cnt_next  = r_init_cnt;
        w_enable_next    = 1'b0;
        w_up_next        = 1'b0;
        w_down_next      = 1'b0;
        w_err_next       = 1'b0;
        w_dir_next       = r_dir;
        w_err_count_next = r_err_count;
        case (r_state)
            ST_INIT: begin
                // prev follows the bypassed level so an idle non-00 pin state is not seen as a step.
                w_filt_next  = w_sync;
                w_prev_next  = w_sync;
                w_cnt_a_next = {CNT_W{1'b0}};
                w_cnt_b_next = {CNT_W{1'b0}};
                if (r_init_cnt == 2'd2) begin
                    w_state_next    = ST_RUN;
                    w_init_cnt_next = 2'd0;
                end else begin
                    w_init_cnt_next = r_init_cnt + 2'd1;
                end
            end
            ST_RUN: begin
                w_filt_next  = {w_step_a[CNT_W], w_step_b[CNT_W]};
                w_cnt_a_next = w_step_a[CNT_W-1:0];
                w_cnt_b_next = w_step_b[CNT_W-1:0];
                w_prev_next  = r_filt;
                if (dec_en) begin
                    case ({r_prev, r_filt})
                        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
                            w_enable_next = 1'b1;
                            w_up_next     = 1'b1;
                            w_dir_next    = 1'b1;
                        end
                        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
                            w_enable_next = 1'b1;
                            w_down_next   = 1'b1;
                            w_dir_next    = 1'b0;
                        end
                        4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: begin
                            w_err_next = 1'b1;
                            if (r_err_count != ERR_MAX) begin
                                w_err_count_next = r_err_count + {{(ERR_W-1){1'b0}}, 1'b1};
                            end else begin
                                w_err_count_next = r_err_count;
                            end
                        end
                        default: begin
                            w_enable_next = 1'b0;
                        end
                    endcase
                end else begin
                    w_enable_next = 1'b0;
                end
            end
            default: begin
                w_state_next    = ST_INIT;
                w_init_cnt_next = 2'd0;
            end
        endcase
    end

    // Synchronisers, filter/decode state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_meta    <= 1'b0;
            r_a_sync    <= 1'b0;
            r_b_meta    <= 1'b0;
            r_b_sync    <= 1'b0;
            r_filt      <= 2'b00;
            r_prev      <= 2'b00;
            r_cnt_a     <= {CNT_W{1'b0}};
            r_cnt_b     <= {CNT_W{1'b0}};
            r_init_cnt  <= 2'd0;
            r_enable    <= 1'b0;
            r_up        <= 1'b0;
            r_down      <= 1'b0;
            r_err       <= 1'b0;
            r_dir       <= 1'b0;
            r_err_count <= {ERR_W{1'b0}};
        end else begin
            r_a_meta    <= quad_a;
            r_a_sync    <= r_a_meta;
            r_b_meta    <= quad_b;
            r_b_sync    <= r_b_meta;
            r_filt      <= w_filt_next;
            r_prev      <= w_prev_next;
            r_cnt_a     <= w_cnt_a_next;
            r_cnt_b     <= w_cnt_b_next;
            r_init_cnt  <= w_init_cnt_next;
            r_enable    <= w_enable_next;
            r_up        <= w_up_next;
            r_down      <= w_down_next;
            r_err       <= w_err_next;
            r_dir       <= w_dir_next;
            r_err_count <= w_err_count_next;
        end
    end

    assign enable    = r_enable;
    assign up_en     = r_up;
    assign down_en   = r_down;
    assign err       = r_err;
    assign dir       = r_dir;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: a reference model predicts pulses into a queue and a
// separate monitor pops and compares them whenever the DUT raises enable or err.
module tb_quad_step_decoder;

    localparam int FILT_LEN = 4;
    localparam int ERR_W    = 8;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             reset, quad_a, quad_b, dec_en;
    logic             enable, up_en, down_en, dir, err;
    logic [ERR_W-1:0] err_count;

    quad_step_decoder #(.FILT_LEN(FILT_LEN), .ERR_W(ERR_W)) dut (
        .clk(clk), .reset(reset), .quad_a(quad_a), .quad_b(quad_b), .dec_en(dec_en),
        .enable(enable), .up_en(up_en), .down_en(down_en), .dir(dir), .err(err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct { int edge_no; bit is_err; bit up; } ev_t;
    ev_t exp_q[$];

    int n_cmp = 0, n_bad = 0, e = 0;
    int seen_up = 0, seen_down = 0, seen_err = 0, last_en_edge = -1;

    // Reference model state: position along the Gray cycle, pin delay line, filter history.
    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0] m_meta = 2'b00, m_sync = 2'b00, m_filt = 2'b00, m_prev = 2'b00;
    logic [1:0] m_hist[$];
    bit         m_run = 1'b0, m_dir = 1'b0;
    int         m_icnt = 0, m_errc = 0;
    logic       cur_a = 1'b0, cur_b = 1'b0, cur_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, expv, e);
        end
    endtask

    function automatic int pos(input logic [1:0] v);
        int r = 0;
        for (int i = 0; i < 4; i++) if (seq[i] == v) r = i;
        return r;
    endfunction

    task automatic model_edge(input logic pa, input logic pb, input logic en, input logic rst);
        logic [1:0] sync_old, filt_old, prev_old;
        int d;
        if (rst) begin
            m_meta = 2'b00; m_sync = 2'b00; m_filt = 2'b00; m_prev = 2'b00;
            m_run = 1'b0; m_icnt = 0; m_hist.delete(); m_dir = 1'b0; m_errc = 0;
            return;
        end
        sync_old = m_sync; filt_old = m_filt; prev_old = m_prev;
        m_sync = m_meta;
        m_meta = {pa, pb};
        if (!m_run) begin
            m_filt = sync_old;
            m_prev = sync_old;
            m_hist.delete();
            m_icnt++;
            if (m_icnt == 3) m_run = 1'b1;
            return;
        end
        // A phase's filtered level flips once the last FILT_LEN synced samples all disagree with it.
        m_hist.push_back(sync_old);
        if (m_hist.size() > FILT_LEN) void'(m_hist.pop_front());
        for (int ph = 0; ph < 2; ph++) begin
            bit all_diff;
            all_diff = (m_hist.size() == FILT_LEN);
            foreach (m_hist[i]) if (m_hist[i][ph] == filt_old[ph]) all_diff = 1'b0;
            if (all_diff) m_filt[ph] = sync_old[ph];
        end
        m_prev = filt_old;
        if (en && filt_old != prev_old) begin
            d = (pos(filt_old) - pos(prev_old) + 4) % 4;
            if (d == 1) begin
                exp_q.push_back('{e, 1'b0, 1'b1}); m_dir = 1'b1;
            end else if (d == 3) begin
                exp_q.push_back('{e, 1'b0, 1'b0}); m_dir = 1'b0;
            end else begin
                exp_q.push_back('{e, 1'b1, 1'b0});
                if (m_errc < ERR_MAX) m_errc++;
            end
        end
    endtask

    task automatic tick(input logic rst);
        quad_a = cur_a; quad_b = cur_b; dec_en = cur_en; reset = rst;
        @(posedge clk);
        e++;
        model_edge(cur_a, cur_b, cur_en, rst);
        @(negedge clk);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic set_pins(input logic [1:0] v);
        cur_a = v[1]; cur_b = v[0];
    endtask

    // Monitor: per-cycle invariants plus scoreboard pops on every DUT pulse.
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            chk("dir", dir, m_dir);
            chk("err_count", err_count, m_errc);
            chk("up_and_down", up_en & down_en, 0);
            chk("strobe_without_enable", (up_en | down_en) & ~enable, 0);
            chk("err_with_enable", err & enable, 0);
            while (exp_q.size() > 0 && exp_q[0].edge_no < e) begin
                ev = exp_q.pop_front();
                chk("missed_pulse", e, ev.edge_no);
            end
            if (enable || err) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_pulse", {enable, err}, 0);
                end else begin
                    ev = exp_q.pop_front();
                    chk("pulse_edge", e, ev.edge_no);
                    chk("pulse_err", err, ev.is_err);
                    chk("pulse_up", up_en, !ev.is_err && ev.up);
                    chk("pulse_down", down_en, !ev.is_err && !ev.up);
                end
                if (up_en) seen_up++;
                if (down_en) seen_down++;
                if (err) seen_err++;
                if (enable) last_en_edge = e;
            end else if (exp_q.size() > 0 && exp_q[0].edge_no == e) begin
                ev = exp_q.pop_front();
                chk("missed_pulse", 0, 1);
            end
        end
    end

    initial begin
        int u0, d0, r0, k;
        logic [1:0] up_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        logic [1:0] dn_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

        set_pins(2'b00); cur_en = 1'b1;
        tick(1'b1); tick(1'b1);
        chk("reset_outputs", {enable, up_en, down_en, err, dir}, 0);
        chk("reset_err_count", err_count, 0);
        hold(10);

        u0 = seen_up; d0 = seen_down; r0 = seen_err; k = 0;
        for (int i = 0; i < 4; i++) begin set_pins(up_seq[i]); k = e + 1; hold(10); end
        chk("up_pulses", seen_up - u0, 4);
        chk("up_latency", last_en_edge, k + 6);
        chk("up_dir", dir, 1);
        chk("up_err_count", err_count, 0);
        chk("up_no_down", seen_down - d0 + seen_err - r0, 0);

        u0 = seen_up; d0 = seen_down; r0 = seen_err;
        set_pins(2'b11); hold(12);
        chk("illegal_one_err", seen_err - r0, 1);
        chk("illegal_no_step", seen_up - u0 + seen_down - d0, 0);
        chk("illegal_err_count", err_count, 1);
        chk("illegal_dir_kept", dir, 1);
        set_pins(2'b00); hold(12);
        chk("illegal_back_err_count", err_count, 2);

        u0 = seen_up; d0 = seen_down;
        for (int i = 0; i < 4; i++) begin set_pins(dn_seq[i]); k = e + 1; hold(10); end
        chk("down_pulses", seen_down - d0, 4);
        chk("down_latency", last_en_edge, k + 6);
        chk("down_dir", dir, 0);
        chk("down_no_up", seen_up - u0, 0);

        u0 = seen_up; d0 = seen_down; r0 = seen_err;
        set_pins(2'b10); hold(3); set_pins(2'b00); hold(15);
        chk("glitch_rejected", seen_up - u0 + seen_down - d0 + seen_err - r0, 0);

        for (int s = 0; s < 150; s++) begin
            set_pins(2'($urandom_range(0, 3)));
            cur_en = ($urandom_range(0, 7) != 0);
            hold($urandom_range(1, 12));
        end
        cur_en = 1'b1; set_pins(2'b00); hold(12);

        for (int t = 0; t < 300; t++) begin
            set_pins((t % 2 == 0) ? 2'b11 : 2'b00); hold(6);
        end
        hold(4);
        chk("err_count_saturated", err_count, ERR_MAX);

        set_pins(2'b00); tick(1'b1); hold(10);
        u0 = seen_up; d0 = seen_down; r0 = seen_err;
        cur_en = 1'b0; set_pins(2'b01); hold(10);
        cur_en = 1'b1; hold(10);
        chk("disabled_no_strobe", seen_up - u0 + seen_down - d0 + seen_err - r0, 0);
        set_pins(2'b11); hold(10);
        chk("prev_tracked_while_disabled", seen_up - u0, 1);

        set_pins(2'b01); hold(10);
        set_pins(2'b11); hold(3);
        tick(1'b1);
        chk("midstep_reset_outputs", {enable, up_en, down_en, err, dir}, 0);
        chk("midstep_reset_err_count", err_count, 0);
        u0 = seen_up; d0 = seen_down; r0 = seen_err;
        hold(20);
        chk("idle_11_after_init", seen_up - u0 + seen_down - d0 + seen_err - r0, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
